// File: rtl/food_placer_if.sv
// food_placer_if: request, LFSR, occupancy-query and food-result signals of the food placer
interface food_placer_if;
   logic       req;
   logic [7:0] rand_x;
   logic [7:0] rand_y;
   logic       lfsr_ce;
   logic [7:0] occ_x;
   logic [7:0] occ_y;
   logic       occ_hit;
   logic [7:0] food_x;
   logic [7:0] food_y;
   logic       food_valid;
   logic       busy;
   logic       fail;
   modport slave (
      input  req, rand_x, rand_y, occ_hit,
      output lfsr_ce, occ_x, occ_y, food_x, food_y, food_valid, busy, fail
   );
   modport master (
      output req, rand_x, rand_y, occ_hit,
      input  lfsr_ce, occ_x, occ_y, food_x, food_y, food_valid, busy, fail
   );
endinterface

// File: rtl/food_placer.sv
// food_placer: draws LFSR candidates until a free in-grid cell is found; FOOD_FALLBACK_SCAN_EN adds a row-major scan on exhaustion
module food_placer #(
   parameter int GRID_W    = 80,
   parameter int GRID_H    = 60,
   parameter int MAX_TRIES = 32
) (
   input logic         clk,
   input logic         rst_n,
   food_placer_if.slave bus
);
   localparam logic [8:0] W9 = 9'(GRID_W);
   localparam logic [8:0] H9 = 9'(GRID_H);
   localparam logic [7:0] TM = 8'(MAX_TRIES);
   localparam logic [7:0] LX = 8'(GRID_W - 1);
   localparam logic [7:0] LY = 8'(GRID_H - 1);

   typedef enum logic [2:0] {
      IDLE,
      DRAW,
      SAMPLE,
      QUERY,
      CHECK
`ifdef FOOD_FALLBACK_SCAN_EN
      ,
      SCAN,
      SCHECK
`endif
   } state_t;

   state_t     state, nxt;
   logic [7:0] tries, tries_n;
   logic [7:0] occ_x, occ_x_n, occ_y, occ_y_n;
   logic [7:0] food_x, food_x_n, food_y, food_y_n;
   logic       food_valid, food_valid_n;
   logic       fail, fail_n;
   logic       retry;
   logic       out_of_range;

   assign out_of_range = ({1'b0, bus.rand_x} >= W9) || ({1'b0, bus.rand_y} >= H9);

   // next-state and datapath updates; a failed try either redraws or falls into exhaustion
   always_comb begin
      nxt          = state;
      tries_n      = tries;
      occ_x_n      = occ_x;
      occ_y_n      = occ_y;
      food_x_n     = food_x;
      food_y_n     = food_y;
      food_valid_n = food_valid;
      fail_n       = 1'b0;
      retry        = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req) begin
               nxt          = DRAW;
               food_valid_n = 1'b0;
               tries_n      = '0;
            end
         end
         DRAW: begin
            tries_n = tries + 8'd1;
            nxt     = SAMPLE;
         end
         SAMPLE: begin
            if (out_of_range) begin
               retry = 1'b1;
            end else begin
               occ_x_n = bus.rand_x;
               occ_y_n = bus.rand_y;
               nxt     = QUERY;
            end
         end
         QUERY: nxt = CHECK;
         CHECK: begin
            if (bus.occ_hit) begin
               retry = 1'b1;
            end else begin
               food_x_n     = occ_x;
               food_y_n     = occ_y;
               food_valid_n = 1'b1;
               nxt          = IDLE;
            end
         end
`ifdef FOOD_FALLBACK_SCAN_EN
         SCAN: nxt = SCHECK;
         SCHECK: begin
            if (!bus.occ_hit) begin
               food_x_n     = occ_x;
               food_y_n     = occ_y;
               food_valid_n = 1'b1;
               nxt          = IDLE;
            end else if (occ_x == LX && occ_y == LY) begin
               fail_n = 1'b1;
               nxt    = IDLE;
            end else begin
               occ_x_n = (occ_x == LX) ? 8'd0 : occ_x + 8'd1;
               occ_y_n = (occ_x == LX) ? occ_y + 8'd1 : occ_y;
               nxt     = SCAN;
            end
         end
`endif
         default: nxt = IDLE;
      endcase
      if (retry) begin
         if (tries < TM) begin
            nxt = DRAW;
         end else begin
`ifdef FOOD_FALLBACK_SCAN_EN
            occ_x_n = 8'd0;
            occ_y_n = 8'd0;
            nxt     = SCAN;
`else
            fail_n = 1'b1;
            nxt    = IDLE;
`endif
         end
      end
   end

   // state and datapath registers; reset aborts any placement without a FAIL pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tries      <= '0;
         occ_x      <= '0;
         occ_y      <= '0;
         food_x     <= '0;
         food_y     <= '0;
         food_valid <= 1'b0;
         fail       <= 1'b0;
      end else begin
         state      <= nxt;
         tries      <= tries_n;
         occ_x      <= occ_x_n;
         occ_y      <= occ_y_n;
         food_x     <= food_x_n;
         food_y     <= food_y_n;
         food_valid <= food_valid_n;
         fail       <= fail_n;
      end
   end

   assign bus.lfsr_ce    = (state == DRAW);
   assign bus.busy       = (state != IDLE);
   assign bus.occ_x      = occ_x;
   assign bus.occ_y      = occ_y;
   assign bus.food_x     = food_x;
   assign bus.food_y     = food_y;
   assign bus.food_valid = food_valid;
   assign bus.fail       = fail;
endmodule

// File: tb/tb_food_placer.sv
// tb_food_placer: scoreboard bench for food_placer with LFSR and occupancy models
module tb_food_placer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   food_placer_if bus ();
   food_placer #(.GRID_W(80), .GRID_H(60), .MAX_TRIES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic       fail;
      logic [7:0] x;
      logic [7:0] y;
      int         ces;
      int         lat;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] draws[$];
   logic [15:0] occ_log[$];
   logic [15:0] last_occ = '0;
   logic        fv_prev = 1'b0;
   int          n_tests = 0, n_fail = 0, n_done = 0;
   int          cyc = 0, t0 = 0, ce_cnt = 0, ce_base = 0, occ_base = 0;
   int          occ_mode = 0;

   function automatic logic occupied(input logic [7:0] x, input logic [7:0] y);
      case (occ_mode)
         1:       return x == 8'd3 && y == 8'd3;
         2:       return !(x == 8'd2 && y == 8'd1);
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // environment: LFSR stub advances on lfsr_ce, occupancy memory answers one cycle later
   always @(posedge clk) begin
      cyc <= cyc + 1;
      bus.occ_hit <= occupied(bus.occ_x, bus.occ_y);
      if (bus.lfsr_ce && draws.size() > 0) {bus.rand_x, bus.rand_y} <= draws.pop_front();
   end

   // monitor: counts draws, logs queries and checks each completion against the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (bus.lfsr_ce) ce_cnt++;
      if (bus.busy && {bus.occ_x, bus.occ_y} !== last_occ) occ_log.push_back({bus.occ_x, bus.occ_y});
      last_occ = {bus.occ_x, bus.occ_y};
      if ((bus.food_valid && !fv_prev) || bus.fail) begin
         n_done++;
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("fail", bus.fail, e.fail);
            chk("food_valid", bus.food_valid, !e.fail);
            chk("food_x", bus.food_x, e.x);
            chk("food_y", bus.food_y, e.y);
            chk("lfsr_ce_count", ce_cnt - ce_base, e.ces);
            if (e.lat >= 0) chk("latency", cyc - t0, e.lat);
         end
      end
      fv_prev = bus.food_valid;
   end

   task automatic run_req(input exp_t e, input bit busy_req);
      int         d0;
      logic [7:0] px;
      @(negedge clk);
      px = bus.food_x;
      bus.req = 1'b1;
      ce_base = ce_cnt;
      occ_base = occ_log.size();
      d0 = n_done;
      sb.push_back(e);
      @(posedge clk);
      #1 t0 = cyc;
      chk("valid_cleared_on_req", bus.food_valid, 0);
      chk("food_x_held_on_req", bus.food_x, px);
      @(negedge clk) bus.req = 1'b0;
      if (busy_req) begin
         repeat (2) @(negedge clk);
         bus.req = 1'b1;
         @(negedge clk) bus.req = 1'b0;
      end
      for (int i = 0; i < 400 && n_done == d0; i++) @(negedge clk);
      chk("completion_seen", n_done != d0, 1);
   endtask

   initial begin
      exp_t e;
      bus.req = 1'b0;
      bus.rand_x = '0;
      bus.rand_y = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_lfsr_ce", bus.lfsr_ce, 0);
      chk("rst_food_valid", bus.food_valid, 0);
      chk("rst_food_xy", {bus.food_x, bus.food_y}, 0);
      chk("rst_occ_xy", {bus.occ_x, bus.occ_y}, 0);
      chk("rst_fail", bus.fail, 0);
      rst_n = 1'b1;

      occ_mode = 0;
      draws.push_back({8'h10, 8'h05});
      e = '{1'b0, 8'd16, 8'd5, 1, 4};
      run_req(e, 0);
      chk("direct_queries", occ_log.size() - occ_base, 1);
      chk("direct_query_xy", occ_log[occ_base], {8'd16, 8'd5});

      draws.push_back({8'h5A, 8'h00});
      draws.push_back({8'h20, 8'h07});
      e = '{1'b0, 8'd32, 8'd7, 2, 6};
      run_req(e, 0);
      chk("oor_queries", occ_log.size() - occ_base, 1);
      chk("oor_query_xy", occ_log[occ_base], {8'd32, 8'd7});

      draws.push_back({8'd79, 8'd60});
      draws.push_back({8'd79, 8'd59});
      e = '{1'b0, 8'd79, 8'd59, 2, 6};
      run_req(e, 0);
      chk("edge_queries", occ_log.size() - occ_base, 1);

      occ_mode = 1;
      draws.push_back({8'd3, 8'd3});
      draws.push_back({8'd4, 8'd3});
      e = '{1'b0, 8'd4, 8'd3, 2, 8};
      run_req(e, 0);
      chk("occ_queries", occ_log.size() - occ_base, 2);
      chk("occ_query1", occ_log[occ_base], {8'd3, 8'd3});
      chk("occ_query2", occ_log[occ_base+1], {8'd4, 8'd3});

      occ_mode = 0;
      draws.push_back({8'd9, 8'd9});
      draws.push_back({8'd11, 8'd11});
      e = '{1'b0, 8'd9, 8'd9, 1, 4};
      run_req(e, 1);
      repeat (10) @(negedge clk);
      chk("busyreq_idle", bus.busy, 0);
      chk("busyreq_one_draw", ce_cnt - ce_base, 1);
      chk("busyreq_sb_empty", sb.size(), 0);

      occ_mode = 2;
      draws.delete();
      draws.push_back({8'd1, 8'd1});
      draws.push_back({8'd5, 8'd5});
      draws.push_back({8'd6, 8'd6});
      draws.push_back({8'd7, 8'd7});
`ifdef FOOD_FALLBACK_SCAN_EN
      e = '{1'b0, 8'd2, 8'd1, 4, 182};
`else
      e = '{1'b1, 8'd9, 8'd9, 4, 16};
`endif
      run_req(e, 0);
      chk("exh_busy_after", bus.busy, 0);
      @(negedge clk);
      chk("exh_fail_one_cycle", bus.fail, 0);

      occ_mode = 0;
      draws.delete();
      draws.push_back({8'd20, 8'd20});
      @(negedge clk) bus.req = 1'b1;
      @(negedge clk) bus.req = 1'b0;
      @(negedge clk);
      chk("midop_busy", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", bus.busy, 0);
      chk("arst_lfsr_ce", bus.lfsr_ce, 0);
      chk("arst_food", {bus.food_valid, bus.food_x, bus.food_y}, 0);
      chk("arst_occ", {bus.occ_x, bus.occ_y}, 0);
      chk("arst_fail", bus.fail, 0);
      repeat (3) @(negedge clk);
      chk("arst_no_done", sb.size(), 0);
      rst_n = 1'b1;
      draws.delete();
      draws.push_back({8'd1, 8'd2});
      e = '{1'b0, 8'd1, 8'd2, 1, 4};
      run_req(e, 0);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
